// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage -- instruction fetch stage
//
// Issues one sequential fetch per cycle to a synchronous instruction memory
// (read data returns one cycle after the request) and presents each returned
// word to decode together with its byte address. A one-entry hold buffer
// catches the response that is still in flight when decode stalls, so a stall
// release produces no bubble. A redirect flushes everything in flight and
// restarts fetching at the word-aligned redirect address.
//
// Parameters
//   WORD_SIZE   datapath / instruction width
//   ADDR_SIZE   instruction-memory word-address width
//   RESET_PC    first fetch byte address after reset
//
// Ports
//   clk          in   sole clock, rising edge
//   rst          in   synchronous active-low reset
//   stall        in   decode cannot accept; if_* outputs hold
//   redirect     in   taken branch/jump; flush and refetch from redirect_pc
//   redirect_pc  in   new fetch byte address (low two bits ignored)
//   imem_en      out  fetch request this cycle
//   imem_addr    out  word address of the request (pc[ADDR_SIZE+1:2])
//   imem_rdata   in   instruction word, valid the cycle after imem_en
//   if_instr     out  instruction presented to decode
//   if_pc        out  byte address of if_instr
//   if_valid     out  if_instr / if_pc hold a live instruction
// -----------------------------------------------------------------------------
module if_stage #(
   parameter int                   WORD_SIZE = 32,
   parameter int                   ADDR_SIZE = 10,
   parameter logic [WORD_SIZE-1:0] RESET_PC  = 32'h0000_0000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall,
   input  logic                 redirect,
   input  logic [WORD_SIZE-1:0] redirect_pc,
   output logic                 imem_en,
   output logic [ADDR_SIZE-1:0] imem_addr,
   input  logic [WORD_SIZE-1:0] imem_rdata,
   output logic [WORD_SIZE-1:0] if_instr,
   output logic [WORD_SIZE-1:0] if_pc,
   output logic                 if_valid
);

   localparam logic [WORD_SIZE-1:0] NOP       = WORD_SIZE'(32'h0000_0013);
   localparam logic [WORD_SIZE-1:0] PC_STEP   = WORD_SIZE'(4);
   localparam logic [WORD_SIZE-1:0] ALIGN_MSK = ~WORD_SIZE'(3);

   typedef enum logic {BOOT, RUN} state_e;

   state_e                 state_q,     state_d;
   logic [WORD_SIZE-1:0]   pc_q,        pc_d;
   logic                   pend_q,      pend_d;
   logic [WORD_SIZE-1:0]   pend_pc_q,   pend_pc_d;
   logic [WORD_SIZE-1:0]   buf_instr_q, buf_instr_d;
   logic [WORD_SIZE-1:0]   buf_pc_q,    buf_pc_d;
   logic                   buf_valid_q, buf_valid_d;
   logic [WORD_SIZE-1:0]   if_instr_q,  if_instr_d;
   logic [WORD_SIZE-1:0]   if_pc_q,     if_pc_d;
   logic                   if_valid_q,  if_valid_d;
   logic                   issue;

   // A fetch goes out only in RUN while decode is accepting and no flush is
   // happening; reset gates the request port directly.
   assign issue     = (state_q == RUN) && !stall && !redirect;
   assign imem_en   = rst && issue;
   // Bit selection alone gives the modulo-2^ADDR_SIZE wrap of the word address.
   assign imem_addr = pc_q[ADDR_SIZE+1:2];

   assign if_instr  = if_instr_q;
   assign if_pc     = if_pc_q;
   assign if_valid  = if_valid_q;

   always_comb begin
      // NOTE: every _d starts as its _q so no path through this block leaves a
      // variable unassigned, which would otherwise infer a latch.
      state_d     = state_q;
      pc_d        = pc_q;
      pend_d      = pend_q;
      pend_pc_d   = pend_pc_q;
      buf_instr_d = buf_instr_q;
      buf_pc_d    = buf_pc_q;
      buf_valid_d = buf_valid_q;
      if_instr_d  = if_instr_q;
      if_pc_d     = if_pc_q;
      if_valid_d  = if_valid_q;

      // BOOT is a single quiet cycle; a redirect inside it only reloads pc.
      case (state_q)
         BOOT:    state_d = RUN;
         RUN:     state_d = RUN;
         default: state_d = BOOT;
      endcase

      if (redirect) begin
         // Flush: the response arriving this cycle (if any) is dropped because
         // pend is cleared without being consumed.
         pc_d        = redirect_pc & ALIGN_MSK;
         pend_d      = 1'b0;
         buf_valid_d = 1'b0;
         if_valid_d  = 1'b0;
      end else begin
         pend_d = issue;
         if (issue) begin
            pc_d      = pc_q + PC_STEP;
            pend_pc_d = pc_q;
         end

         if (stall) begin
            // Decode is holding if_*; park the in-flight word. No fetch is
            // issued while stalled, so the buffer is never asked to take two.
            if (pend_q) begin
               buf_instr_d = imem_rdata;
               buf_pc_d    = pend_pc_q;
               buf_valid_d = 1'b1;
            end
         end else if (pend_q) begin
            if_instr_d = imem_rdata;
            if_pc_d    = pend_pc_q;
            if_valid_d = 1'b1;
         end else if (buf_valid_q) begin
            // Drain cycle; the fetch issued alongside keeps the stream gapless.
            if_instr_d  = buf_instr_q;
            if_pc_d     = buf_pc_q;
            if_valid_d  = 1'b1;
            buf_valid_d = 1'b0;
         end else begin
            if_valid_d = 1'b0;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= BOOT;
         pc_q        <= RESET_PC;
         pend_q      <= 1'b0;
         pend_pc_q   <= '0;
         // NOTE: the hold buffer is a handful of flops, not a RAM, so clearing
         // its data fields on reset costs nothing and keeps them deterministic.
         buf_instr_q <= '0;
         buf_pc_q    <= '0;
         buf_valid_q <= 1'b0;
         if_instr_q  <= NOP;
         if_pc_q     <= '0;
         if_valid_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         pend_q      <= pend_d;
         pend_pc_q   <= pend_pc_d;
         buf_instr_q <= buf_instr_d;
         buf_pc_q    <= buf_pc_d;
         buf_valid_q <= buf_valid_d;
         if_instr_q  <= if_instr_d;
         if_pc_q     <= if_pc_d;
         if_valid_q  <= if_valid_d;
      end
   end

endmodule
